user_id_entry: RTL and testbench

Interactive user-ID entry stage for the authentication screen. It turns four push-button inputs into per-position 5-bit letter/number codes (0 = blank, 1–20 = letters, 21–29 = digits 1–9) and drives them to the per-digit seven-segment letter decoders. The active position blinks. On confirm, the entered ID is latched for the authentication logic.

---
 rtl/user_id_entry.sv | 163 ++++++++++++++++
 tb/tb_user_id_entry.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/user_id_entry.sv
// User-ID entry stage: push-button editing of NUM_POS symbol codes with a blinking
// cursor digit, validation on Enter, and a latched copy of the accepted ID.
module user_id_entry #(
    parameter int NUM_POS   = 4,
    parameter int BLINK_DIV = 25000000,
    parameter int MAX_CODE  = 29
) (
    input  logic                                          Clk,
    input  logic                                          Rst,
    input  logic                                          Enable,
    input  logic                                          BtnUp,
    input  logic                                          BtnDown,
    input  logic                                          BtnNext,
    input  logic                                          BtnEnter,
    output logic [5*NUM_POS-1:0]                          DisplayCodes,
    output logic [((NUM_POS > 2) ? $clog2(NUM_POS) : 1)-1:0] Cursor,
    output logic [5*NUM_POS-1:0]                          UserId,
    output logic                                          EntryDone,
    output logic                                          EntryError,
    output logic                                          Busy
);

    localparam int CW = (NUM_POS > 2) ? $clog2(NUM_POS) : 1;
    localparam int BW = $clog2(BLINK_DIV);

    typedef enum logic [1:0] {IDLE, ENTRY, DONE} state_t;

    state_t          state, state_n;
    logic [4:0]      pos   [NUM_POS];
    logic [4:0]      pos_n [NUM_POS];
    logic [CW-1:0]   cursor_n, first_blank;
    logic [BW-1:0]   cnt, cnt_n;
    logic            blink, blink_n;
    logic [5*NUM_POS-1:0] user_n, disp_n;
    logic            done_n, err_n, all_set;
    logic            prev_en, prev_up, prev_down, prev_next, prev_enter;
    logic            e_en, e_up, e_down, e_next, e_enter;

    // Symbol wrap: 0 and MAX_CODE both step up to 1; 0 and 1 both step down to MAX_CODE.
    function automatic logic [4:0] code_up(input logic [4:0] c);
        if (c >= 5'(MAX_CODE)) return 5'd1;
        return c + 5'd1;
    endfunction

    function automatic logic [4:0] code_down(input logic [4:0] c);
        if (c <= 5'd1) return 5'(MAX_CODE);
        return c - 5'd1;
    endfunction

    assign e_en    = Enable   & ~prev_en;
    assign e_up    = BtnUp    & ~prev_up;
    assign e_down  = BtnDown  & ~prev_down;
    assign e_next  = BtnNext  & ~prev_next;
    assign e_enter = BtnEnter & ~prev_enter;

    always_comb begin
        state_n     = state;
        cursor_n    = Cursor;
        cnt_n       = cnt;
        blink_n     = blink;
        user_n      = UserId;
        done_n      = 1'b0;
        err_n       = 1'b0;
        all_set     = 1'b1;
        first_blank = Cursor;
        disp_n      = '0;
        for (int i = 0; i < NUM_POS; i++) begin
            pos_n[i] = pos[i];
            if (pos[i] == 5'd0) all_set = 1'b0;
        end
        for (int i = NUM_POS - 1; i >= 0; i--) begin
            if (pos[i] == 5'd0) first_blank = CW'(i);
        end

        case (state)
            ENTRY: begin
                if (e_enter) begin
                    cnt_n   = '0;
                    blink_n = 1'b1;
                    if (all_set) begin
                        for (int i = 0; i < NUM_POS; i++) user_n[5*i +: 5] = pos[i];
                        done_n  = 1'b1;
                        state_n = DONE;
                    end else begin
                        err_n    = 1'b1;
                        cursor_n = first_blank;
                    end
                end else if (e_next) begin
                    cursor_n = (Cursor == CW'(NUM_POS - 1)) ? '0 : Cursor + CW'(1);
                    cnt_n    = '0;
                    blink_n  = 1'b1;
                end else if (e_up) begin
                    pos_n[Cursor] = code_up(pos[Cursor]);
                    cnt_n         = '0;
                    blink_n       = 1'b1;
                end else if (e_down) begin
                    pos_n[Cursor] = code_down(pos[Cursor]);
                    cnt_n         = '0;
                    blink_n       = 1'b1;
                end else if (cnt == BW'(BLINK_DIV - 1)) begin
                    cnt_n   = '0;
                    blink_n = ~blink;
                end else begin
                    cnt_n = cnt + BW'(1);
                end
            end
            default: begin
                // IDLE and DONE share the same way into a fresh entry.
                cnt_n   = '0;
                blink_n = 1'b1;
                if (e_en) begin
                    state_n  = ENTRY;
                    cursor_n = '0;
                    for (int i = 0; i < NUM_POS; i++) pos_n[i] = 5'd0;
                end
            end
        endcase

        if (state_n == DONE) begin
            disp_n = user_n;
        end else if (state_n == ENTRY) begin
            for (int i = 0; i < NUM_POS; i++)
                disp_n[5*i +: 5] = (CW'(i) == cursor_n && !blink_n) ? 5'd0 : pos_n[i];
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state        <= IDLE;
            prev_en      <= 1'b1;
            prev_up      <= 1'b1;
            prev_down    <= 1'b1;
            prev_next    <= 1'b1;
            prev_enter   <= 1'b1;
            pos          <= '{default: 5'd0};
            Cursor       <= '0;
            cnt          <= '0;
            blink        <= 1'b1;
            UserId       <= '0;
            DisplayCodes <= '0;
            EntryDone    <= 1'b0;
            EntryError   <= 1'b0;
            Busy         <= 1'b0;
        end else begin
            state        <= state_n;
            prev_en      <= Enable;
            prev_up      <= BtnUp;
            prev_down    <= BtnDown;
            prev_next    <= BtnNext;
            prev_enter   <= BtnEnter;
            pos          <= pos_n;
            Cursor       <= cursor_n;
            cnt          <= cnt_n;
            blink        <= blink_n;
            UserId       <= user_n;
            DisplayCodes <= disp_n;
            EntryDone    <= done_n;
            EntryError   <= err_n;
            Busy         <= (state_n == ENTRY);
        end
    end

endmodule

// File: tb/tb_user_id_entry.sv
// Bench for user_id_entry: a behavioural model checked every cycle plus directed
// button sequences with hand-computed expectations.
module tb_user_id_entry;

    localparam int NP = 4;
    localparam int BD = 4;
    localparam int MC = 29;

    logic Clk = 1'b0;
    logic Rst, Enable, BtnUp, BtnDown, BtnNext, BtnEnter;
    logic [5*NP-1:0] DisplayCodes, UserId;
    logic [1:0]      Cursor;
    logic            EntryDone, EntryError, Busy;

    int checks = 0;
    int errors = 0;

    user_id_entry #(.NUM_POS(NP), .BLINK_DIV(BD), .MAX_CODE(MC)) dut (
        .Clk(Clk), .Rst(Rst), .Enable(Enable), .BtnUp(BtnUp), .BtnDown(BtnDown),
        .BtnNext(BtnNext), .BtnEnter(BtnEnter), .DisplayCodes(DisplayCodes),
        .Cursor(Cursor), .UserId(UserId), .EntryDone(EntryDone),
        .EntryError(EntryError), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: mode 0 = idle, 1 = entry, 2 = done; t counts cycles since entry/action.
    int m_mode = 0;
    int m_code [NP];
    int m_uid  [NP];
    int m_cur  = 0;
    int m_t    = 0;
    bit m_done = 0, m_err = 0;
    bit p_en = 1, p_up = 1, p_dn = 1, p_nx = 1, p_ent = 1;

    initial begin
        logic [5*NP-1:0] ed, eu;
        bit eg_en, eg_up, eg_dn, eg_nx, eg_ent;
        int blank;
        for (int i = 0; i < NP; i++) begin m_code[i] = 0; m_uid[i] = 0; end
        forever begin
            @(negedge Clk);
            ed = '0;
            eu = '0;
            for (int i = 0; i < NP; i++) begin
                eu[5*i +: 5] = 5'(m_uid[i]);
                if (m_mode == 2) ed[5*i +: 5] = 5'(m_uid[i]);
                else if (m_mode == 1)
                    ed[5*i +: 5] = (i == m_cur && ((m_t / BD) % 2) == 1) ? 5'd0 : 5'(m_code[i]);
            end
            chk("display", 64'(DisplayCodes), 64'(ed));
            chk("cursor",  64'(Cursor),       64'(m_cur));
            chk("userid",  64'(UserId),       64'(eu));
            chk("done",    64'(EntryDone),    64'(m_done));
            chk("error",   64'(EntryError),   64'(m_err));
            chk("busy",    64'(Busy),         64'(m_mode == 1));

            // Advance the model with the inputs the next rising edge will sample.
            m_done = 0;
            m_err  = 0;
            if (Rst) begin
                m_mode = 0; m_cur = 0; m_t = 0;
                for (int i = 0; i < NP; i++) begin m_code[i] = 0; m_uid[i] = 0; end
                p_en = 1; p_up = 1; p_dn = 1; p_nx = 1; p_ent = 1;
            end else begin
                eg_en  = Enable   && !p_en;
                eg_up  = BtnUp    && !p_up;
                eg_dn  = BtnDown  && !p_dn;
                eg_nx  = BtnNext  && !p_nx;
                eg_ent = BtnEnter && !p_ent;
                p_en = Enable; p_up = BtnUp; p_dn = BtnDown; p_nx = BtnNext; p_ent = BtnEnter;
                if (m_mode != 1) begin
                    if (eg_en) begin
                        m_mode = 1; m_cur = 0; m_t = 0;
                        for (int i = 0; i < NP; i++) m_code[i] = 0;
                    end
                end else if (eg_ent) begin
                    blank = -1;
                    for (int i = NP - 1; i >= 0; i--) if (m_code[i] == 0) blank = i;
                    if (blank < 0) begin
                        for (int i = 0; i < NP; i++) m_uid[i] = m_code[i];
                        m_done = 1; m_mode = 2;
                    end else begin
                        m_err = 1; m_cur = blank;
                    end
                    m_t = 0;
                end else if (eg_nx) begin
                    m_cur = (m_cur + 1) % NP; m_t = 0;
                end else if (eg_up) begin
                    m_code[m_cur] = (m_code[m_cur] >= MC) ? 1 : m_code[m_cur] + 1; m_t = 0;
                end else if (eg_dn) begin
                    m_code[m_cur] = (m_code[m_cur] <= 1) ? MC : m_code[m_cur] - 1; m_t = 0;
                end else begin
                    m_t++;
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic press(input int b);
        case (b)
            0: BtnUp = 1'b1;
            1: BtnDown = 1'b1;
            2: BtnNext = 1'b1;
            default: BtnEnter = 1'b1;
        endcase
        cyc(1);
        BtnUp = 1'b0; BtnDown = 1'b0; BtnNext = 1'b0; BtnEnter = 1'b0;
        cyc(1);
    endtask

    initial begin
        Rst = 1'b1; Enable = 1'b0; BtnUp = 1'b1; BtnDown = 1'b0; BtnNext = 1'b0; BtnEnter = 1'b0;
        cyc(3);
        Rst = 1'b0;
        cyc(2);
        chk("lit_reset_disp", 64'(DisplayCodes), 64'd0);
        chk("lit_reset_busy", 64'(Busy), 64'd0);
        BtnUp = 1'b0; cyc(1);
        BtnUp = 1'b1; cyc(1);
        chk("lit_idle_up_ignored", 64'(DisplayCodes), 64'd0);
        BtnUp = 1'b0;

        Enable = 1'b1; cyc(1);
        chk("lit_entry_busy", 64'(Busy), 64'd1);
        repeat (3) press(0);
        chk("lit_up3", 64'(DisplayCodes[4:0]), 64'd3);
        press(2);
        press(1);
        chk("lit_down_from0", 64'(DisplayCodes[9:5]), 64'd29);
        press(0);
        chk("lit_up_from29", 64'(DisplayCodes[9:5]), 64'd1);

        cyc(3);
        chk("lit_blink_off", 64'(DisplayCodes[9:5]), 64'd0);
        cyc(2);
        BtnUp = 1'b1; cyc(1);
        chk("lit_up_in_off_phase", 64'(DisplayCodes[9:5]), 64'd2);
        BtnUp = 1'b0; cyc(1);
        cyc(12);

        repeat (3) press(2);
        chk("lit_cursor_wrap_to0", 64'(Cursor), 64'd0);
        for (int k = 1; k <= NP; k++) begin
            press(2);
            chk("lit_next_seq", 64'(Cursor), 64'(k % NP));
        end

        BtnUp = 1'b1; BtnNext = 1'b1; cyc(1);
        chk("lit_up_next_cursor", 64'(Cursor), 64'd1);
        chk("lit_up_next_code", 64'(DisplayCodes[4:0]), 64'd3);
        chk("lit_up_next_pos1", 64'(DisplayCodes[9:5]), 64'd2);
        BtnUp = 1'b0; BtnNext = 1'b0; cyc(1);

        press(2); press(2);
        press(0);
        BtnEnter = 1'b1; cyc(1);
        chk("lit_err_pulse", 64'(EntryError), 64'd1);
        chk("lit_err_cursor", 64'(Cursor), 64'd2);
        chk("lit_err_busy", 64'(Busy), 64'd1);
        BtnEnter = 1'b0; cyc(1);
        chk("lit_err_one_cycle", 64'(EntryError), 64'd0);

        press(1);
        BtnEnter = 1'b1; cyc(1);
        chk("lit_done_pulse", 64'(EntryDone), 64'd1);
        chk("lit_done_busy", 64'(Busy), 64'd0);
        chk("lit_userid", 64'(UserId), 64'({5'd1, 5'd29, 5'd2, 5'd3}));
        BtnEnter = 1'b0; cyc(1);
        chk("lit_done_one_cycle", 64'(EntryDone), 64'd0);
        cyc(10);
        chk("lit_done_steady", 64'(DisplayCodes), 64'({5'd1, 5'd29, 5'd2, 5'd3}));
        press(0);
        chk("lit_done_btn_ignored", 64'(DisplayCodes), 64'({5'd1, 5'd29, 5'd2, 5'd3}));

        Enable = 1'b0; cyc(1);
        Enable = 1'b1; cyc(1);
        chk("lit_reentry_disp", 64'(DisplayCodes), 64'd0);
        chk("lit_reentry_uid_kept", 64'(UserId), 64'({5'd1, 5'd29, 5'd2, 5'd3}));
        press(0); press(2); press(1);

        Rst = 1'b1; cyc(1);
        chk("lit_rst_uid", 64'(UserId), 64'd0);
        chk("lit_rst_disp", 64'(DisplayCodes), 64'd0);
        chk("lit_rst_busy", 64'(Busy), 64'd0);
        chk("lit_rst_cursor", 64'(Cursor), 64'd0);
        Rst = 1'b0;
        cyc(4);
        chk("lit_after_rst_idle", 64'(Busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
